// File: rtl/bus_pkg.sv
// Shared system-bus definitions: arbiter state encoding, fixed peripheral
// addresses used by the bootloader and decoder, and the default ack timeout.
package bus_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic [31:0] MEM_BASE   = 32'h0000_0000;
    localparam logic [31:0] SPART_BASE = 32'h4000_001C;

    localparam int BUS_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after `last`, or only
// master 0 while the exclusive lock is held.
module rr_picker #(
    parameter int NUM_M = 3,
    parameter int IW    = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    last,
    input  logic             lock0,
    output logic             valid,
    output logic [NUM_M-1:0] winner
);

    logic [IW-1:0] idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        if (lock0) begin
            valid     = req[0];
            winner[0] = req[0];
        end else begin
            for (int i = 1; i <= NUM_M; i++) begin
                idx = IW'((int'(last) + i) % NUM_M);
                if (!valid && req[idx]) begin
                    valid       = 1'b1;
                    winner[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus with a master-0 exclusive lock,
// a registered grant and a per-transaction ack timeout.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_M   = 3,
    parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lock0_i,
    input  logic [NUM_M-1:0]   m_read_i,
    input  logic [NUM_M-1:0]   m_write_i,
    input  logic [NUM_M*32-1:0] m_addr_i,
    input  logic [NUM_M*32-1:0] m_wdata_i,
    output logic [NUM_M-1:0]   m_ack_o,
    output logic [NUM_M-1:0]   m_err_o,
    output logic [31:0]        m_rdata_o,
    output logic               s_read_o,
    output logic               s_write_o,
    output logic [31:0]        s_addr_o,
    output logic [31:0]        s_wdata_o,
    input  logic [31:0]        s_rdata_i,
    input  logic               s_ack_i,
    output logic [NUM_M-1:0]   grant_o,
    output logic               debug_state
);

    localparam int IW = $clog2(NUM_M);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_M - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

    arb_state_t       state_q, state_d;
    logic [NUM_M-1:0] grant_q;
    logic [IW-1:0]    gidx_q;
    logic [IW-1:0]    last_q;
    logic [CW-1:0]    cnt_q;
    logic [31:0]      rdata_q;

    logic             pick_valid;
    logic [NUM_M-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic [31:0]      addr_arr  [NUM_M];
    logic [31:0]      wdata_arr [NUM_M];
    logic             g_read, g_write;
    logic             load, done, ack, err, drive_strobes;

    rr_picker #(.NUM_M(NUM_M), .IW(IW)) u_picker (
        .req    (m_read_i | m_write_i),
        .last   (last_q),
        .lock0  (lock0_i),
        .valid  (pick_valid),
        .winner (pick_onehot)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_M; k++) begin
            addr_arr[k]  = m_addr_i[32*k +: 32];
            wdata_arr[k] = m_wdata_i[32*k +: 32];
            if (pick_onehot[k]) pick_idx = IW'(k);
        end
    end

    assign g_read  = m_read_i[gidx_q];
    assign g_write = m_write_i[gidx_q];

    // Priority inside BUSY: slave ack, then master abort, then timeout.
    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        done          = 1'b0;
        ack           = 1'b0;
        err           = 1'b0;
        drive_strobes = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (s_ack_i) begin
                    ack           = 1'b1;
                    drive_strobes = 1'b1;
                    done          = 1'b1;
                end else if (!(g_read || g_write)) begin
                    done = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    ack  = 1'b1;
                    err  = 1'b1;
                    done = 1'b1;
                end else begin
                    drive_strobes = 1'b1;
                end
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Write wins when a master raises both strobes.
    assign s_write_o   = drive_strobes & g_write;
    assign s_read_o    = drive_strobes & g_read & ~g_write;
    assign s_addr_o    = (state_q == BUSY) ? addr_arr[gidx_q]  : '0;
    assign s_wdata_o   = (state_q == BUSY) ? wdata_arr[gidx_q] : '0;
    assign m_ack_o     = ack ? grant_q : '0;
    assign m_err_o     = err ? grant_q : '0;
    assign m_rdata_o   = (ack && !err) ? s_rdata_i : rdata_q;
    assign grant_o     = grant_q;
    assign debug_state = (state_q == BUSY);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                grant_q <= pick_onehot;
                gidx_q  <= pick_idx;
                cnt_q   <= '0;
            end else if (done) begin
                grant_q <= '0;
                last_q  <= gidx_q;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (ack && !err) rdata_q <= s_rdata_i;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level round-robin model.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int NM = 3;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock0 = 1'b0;
    logic [2:0]  m_read = '0;
    logic [2:0]  m_write = '0;
    logic [95:0] m_addr = '0;
    logic [95:0] m_wdata = '0;
    logic [31:0] s_rdata = '0;
    logic        s_ack = 1'b0;

    logic [2:0]  m_ack_o, m_err_o, grant_o;
    logic [31:0] m_rdata_o, s_addr_o, s_wdata_o;
    logic        s_read_o, s_write_o, debug_state;

    int n_chk = 0;
    int n_pass = 0;

    // Random-test model state: pending requests per master.
    logic [2:0]  pend;
    logic [2:0]  wr;
    logic [31:0] addr_m  [3];
    logic [31:0] wdata_m [3];

    bus_arbiter #(.NUM_M(NM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .lock0_i(lock0),
        .m_read_i(m_read), .m_write_i(m_write), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rdata_o(m_rdata_o),
        .s_read_o(s_read_o), .s_write_o(s_write_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_rdata_i(s_rdata), .s_ack_i(s_ack), .grant_o(grant_o), .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m_read = '0; m_write = '0; s_ack = 1'b0; lock0 = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    function automatic int rr_next(input int last, input logic [2:0] p, input logic lk);
        int j;
        if (lk) return p[0] ? 0 : -1;
        for (int i = 1; i <= NM; i++) begin
            j = (last + i) % NM;
            if (p[j[1:0]]) return j;
        end
        return -1;
    endfunction

    function automatic logic [2:0] onehot(input int idx);
        logic [2:0] v;
        v = '0;
        v[idx[1:0]] = 1'b1;
        return v;
    endfunction

    task automatic drive_masters();
        for (int k = 0; k < NM; k++) begin
            m_read[k]  = pend[k] & ~wr[k];
            m_write[k] = pend[k] & wr[k];
            m_addr[32*k +: 32]  = addr_m[k];
            m_wdata[32*k +: 32] = wdata_m[k];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #7;
        n_chk++; if (grant_o !== 3'b000) $display("FAIL reset_grant: got %b want 000", grant_o); else n_pass++;
        n_chk++; if ({m_ack_o, m_err_o} !== 6'b0) $display("FAIL reset_ack_err: got %b/%b want 000/000", m_ack_o, m_err_o); else n_pass++;
        n_chk++; if ({s_read_o, s_write_o} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {s_read_o, s_write_o}); else n_pass++;
        n_chk++; if ({s_addr_o, s_wdata_o, m_rdata_o} !== 96'b0) $display("FAIL reset_data: got %h %h %h want zeros", s_addr_o, s_wdata_o, m_rdata_o); else n_pass++;
        n_chk++; if (debug_state !== 1'b0) $display("FAIL reset_state: got %b want 0", debug_state); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int pulses;
        do_reset();
        m_write[1] = 1'b1;
        m_addr[63:32]  = SPART_BASE;
        m_wdata[63:32] = 32'h42;
        #1;
        n_chk++; if (grant_o !== 3'b000) $display("FAIL single_no_early_grant: got %b want 000", grant_o); else n_pass++;
        tick();
        n_chk++; if (grant_o !== 3'b010) $display("FAIL single_grant: got %b want 010", grant_o); else n_pass++;
        n_chk++; if ({s_write_o, s_read_o} !== 2'b10) $display("FAIL single_strobes: got w%b r%b want w1 r0", s_write_o, s_read_o); else n_pass++;
        n_chk++; if (s_addr_o !== SPART_BASE || s_wdata_o !== 32'h42) $display("FAIL single_bus: got %h/%h want %h/00000042", s_addr_o, s_wdata_o, SPART_BASE); else n_pass++;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            if (m_ack_o[1]) pulses++;
            tick();
        end
        s_ack = 1'b1;
        #1;
        if (m_ack_o[1]) pulses++;
        n_chk++; if (m_err_o !== 3'b000) $display("FAIL single_err: got %b want 000", m_err_o); else n_pass++;
        tick();
        s_ack = 1'b0;
        m_write = '0;
        #1;
        if (m_ack_o[1]) pulses++;
        n_chk++; if (pulses != 1) $display("FAIL single_ack_pulses: got %0d want 1", pulses); else n_pass++;
        n_chk++; if (grant_o !== 3'b000 || debug_state !== 1'b0) $display("FAIL single_idle_after: got grant %b state %b want 000/0", grant_o, debug_state); else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_m;
        logic [31:0] rd;
        do_reset();
        m_read = 3'b111;
        s_ack = 1'b1;
        exp_m = 0;
        for (int it = 0; it < 6; it++) begin
            tick();
            rd = $urandom;
            s_rdata = rd;
            #1;
            n_chk++; if (grant_o !== onehot(exp_m)) $display("FAIL rr_grant_%0d: got %b want %b", it, grant_o, onehot(exp_m)); else n_pass++;
            n_chk++; if (m_ack_o !== onehot(exp_m) || m_rdata_o !== rd) $display("FAIL rr_ack_%0d: got %b/%h want %b/%h", it, m_ack_o, m_rdata_o, onehot(exp_m), rd); else n_pass++;
            tick();
            n_chk++; if (grant_o !== 3'b000 || debug_state !== 1'b0) $display("FAIL rr_idle_%0d: got %b/%b want 000/0", it, grant_o, debug_state); else n_pass++;
            exp_m = (exp_m + 1) % NM;
        end
        m_read = '0;
        s_ack = 1'b0;
        tick();
    endtask

    task automatic test_lock();
        int bad;
        do_reset();
        lock0 = 1'b1;
        m_read = 3'b110;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (grant_o !== 3'b000) bad++;
        end
        n_chk++; if (bad != 0) $display("FAIL lock_no_grant: got %0d granted cycles want 0", bad); else n_pass++;
        m_read[0] = 1'b1;
        tick();
        n_chk++; if (grant_o !== 3'b001) $display("FAIL lock_m0_grant: got %b want 001", grant_o); else n_pass++;
        lock0 = 1'b0;
        s_ack = 1'b1;
        #1;
        n_chk++; if (m_ack_o !== 3'b001) $display("FAIL lock_m0_ack: got %b want 001", m_ack_o); else n_pass++;
        tick();
        s_ack = 1'b0;
        m_read[0] = 1'b0;
        #1;
        n_chk++; if (grant_o !== 3'b000) $display("FAIL lock_idle: got %b want 000", grant_o); else n_pass++;
        tick();
        n_chk++; if (grant_o !== 3'b010) $display("FAIL lock_m1_after: got %b want 010", grant_o); else n_pass++;
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        m_read = '0;
        tick();
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        m_read[2] = 1'b1;
        tick();
        n_chk++; if (grant_o !== 3'b100) $display("FAIL to_grant: got %b want 100", grant_o); else n_pass++;
        bad = 0;
        for (int c = 1; c < TO; c++) begin
            if (m_ack_o !== 3'b000 || m_err_o !== 3'b000 || s_read_o !== 1'b1) bad++;
            tick();
        end
        n_chk++; if (bad != 0) $display("FAIL to_wait: got %0d bad cycles want 0", bad); else n_pass++;
        n_chk++; if (m_ack_o !== 3'b100 || m_err_o !== 3'b100) $display("FAIL to_pulse: got ack %b err %b want 100/100", m_ack_o, m_err_o); else n_pass++;
        n_chk++; if (s_read_o !== 1'b0) $display("FAIL to_strobe_off: got %b want 0", s_read_o); else n_pass++;
        tick();
        n_chk++; if (debug_state !== 1'b0 || m_ack_o !== 3'b000) $display("FAIL to_idle: got state %b ack %b want 0/000", debug_state, m_ack_o); else n_pass++;
        tick();
        bad = 0;
        for (int c = 1; c < TO; c++) begin
            if (m_ack_o !== 3'b000) bad++;
            tick();
        end
        s_ack = 1'b1;
        #1;
        n_chk++; if (bad != 0 || m_ack_o !== 3'b100 || m_err_o !== 3'b000) $display("FAIL to_ack_wins: got ack %b err %b early %0d want 100/000/0", m_ack_o, m_err_o, bad); else n_pass++;
        tick();
        s_ack = 1'b0;
        m_read = '0;
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        m_read[1] = 1'b1;
        m_write[1] = 1'b1;
        tick();
        n_chk++; if (grant_o !== 3'b010 || s_write_o !== 1'b1 || s_read_o !== 1'b0) $display("FAIL abort_wprio: got g%b w%b r%b want 010/1/0", grant_o, s_write_o, s_read_o); else n_pass++;
        tick();
        m_read = '0;
        m_write = '0;
        #1;
        n_chk++; if (m_ack_o !== 3'b000 || s_write_o !== 1'b0) $display("FAIL abort_no_ack: got ack %b w %b want 000/0", m_ack_o, s_write_o); else n_pass++;
        tick();
        n_chk++; if (grant_o !== 3'b000 || debug_state !== 1'b0 || m_ack_o !== 3'b000) $display("FAIL abort_idle: got g%b s%b a%b want 000/0/000", grant_o, debug_state, m_ack_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_read[0] = 1'b1;
        tick();
        s_rdata = 32'hDEAD_BEEF;
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        m_read = 3'b010;
        tick();
        n_chk++; if (grant_o !== 3'b010 || m_rdata_o !== 32'hDEAD_BEEF) $display("FAIL rmid_setup: got %b/%h want 010/deadbeef", grant_o, m_rdata_o); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (grant_o !== 3'b000 || s_read_o !== 1'b0 || debug_state !== 1'b0) $display("FAIL rmid_async: got g%b r%b s%b want 000/0/0", grant_o, s_read_o, debug_state); else n_pass++;
        n_chk++; if (m_rdata_o !== 32'h0 || m_ack_o !== 3'b000 || m_err_o !== 3'b000) $display("FAIL rmid_outs: got %h/%b/%b want 0/000/000", m_rdata_o, m_ack_o, m_err_o); else n_pass++;
        m_read = 3'b011;
        rst_n = 1'b1;
        tick();
        n_chk++; if (grant_o !== 3'b001) $display("FAIL rmid_first_tie: got %b want 001", grant_o); else n_pass++;
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        m_read = '0;
        tick();
    endtask

    task automatic test_random();
        int model_last, win, lat;
        logic lk;
        logic [31:0] rd;
        do_reset();
        model_last = NM - 1;
        pend = '0;
        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < NM; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    wr[k] = 1'($urandom_range(0, 1));
                    addr_m[k] = $urandom;
                    wdata_m[k] = $urandom;
                end
            end
            if (pend == 3'b000) begin
                pend[1] = 1'b1; wr[1] = 1'b0; addr_m[1] = $urandom; wdata_m[1] = $urandom;
            end
            lk = ($urandom_range(0, 3) == 0);
            lock0 = lk;
            drive_masters();
            win = rr_next(model_last, pend, lk);
            tick();
            if (win < 0) begin
                n_chk++; if (grant_o !== 3'b000) $display("FAIL rnd_lock_block_%0d: got %b want 000", t, grant_o); else n_pass++;
                lock0 = 1'b0;
                win = rr_next(model_last, pend, 1'b0);
                tick();
            end
            lock0 = 1'b0;
            #1;
            n_chk++; if (grant_o !== onehot(win)) $display("FAIL rnd_grant_%0d: got %b want %b", t, grant_o, onehot(win)); else n_pass++;
            n_chk++; if (s_write_o !== wr[win[1:0]] || s_read_o !== !wr[win[1:0]] || s_addr_o !== addr_m[win] || s_wdata_o !== wdata_m[win])
                $display("FAIL rnd_bus_%0d: got w%b r%b %h %h want w%b %h %h", t, s_write_o, s_read_o, s_addr_o, s_wdata_o, wr[win[1:0]], addr_m[win], wdata_m[win]);
            else n_pass++;
            lat = $urandom_range(0, 3);
            for (int c = 0; c < lat; c++) begin
                n_chk++; if (m_ack_o !== 3'b000) $display("FAIL rnd_early_ack_%0d: got %b want 000", t, m_ack_o); else n_pass++;
                tick();
            end
            rd = $urandom;
            s_rdata = rd;
            s_ack = 1'b1;
            #1;
            n_chk++; if (m_ack_o !== onehot(win) || m_err_o !== 3'b000 || m_rdata_o !== rd)
                $display("FAIL rnd_ack_%0d: got %b/%b/%h want %b/000/%h", t, m_ack_o, m_err_o, m_rdata_o, onehot(win), rd);
            else n_pass++;
            tick();
            s_ack = 1'b0;
            pend[win[1:0]] = 1'b0;
            model_last = win;
            drive_masters();
            #1;
            n_chk++; if (grant_o !== 3'b000 || debug_state !== 1'b0) $display("FAIL rnd_idle_%0d: got %b/%b want 000/0", t, grant_o, debug_state); else n_pass++;
        end
        pend = '0;
        drive_masters();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single system bus between NUM_M masters: bootloader (master 0), CPU data port (master 1), and a spare port (master 2, for future DMA).
- The bus consists of read/write strobes, 32-bit address, 32-bit write data, 32-bit read data and a single ack.
- Arbitration is round-robin, with an exclusive lock for master 0 while it holds the CPU in stall.
- Sits between the masters and the address decoder / peripheral fabric (SPART, memory, etc.).
- Replaces the tri-state sharing of the bus with a registered grant and a per-transaction timeout.

Parameters:
- NUM_M, 3: number of bus masters (2..8).
- TIMEOUT, 1024: cycles a granted transaction may wait for s_ack_i before being aborted (>= 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- lock0_i  in  1  exclusive lock: only master 0 may be granted (driven by bootloader stall).
- m_read_i  in  NUM_M  per-master read request.
- m_write_i  in  NUM_M  per-master write request.
- m_addr_i  in  NUM_M*32  per-master address, master k at [32k+31:32k].
- m_wdata_i  in  NUM_M*32  per-master write data, same packing.
- m_ack_o  out  NUM_M  per-master completion pulse.
- m_err_o  out  NUM_M  per-master timeout pulse, coincident with m_ack_o.
- m_rdata_o  out  32  read data returned to all masters (valid when that master's ack is high).
- s_read_o  out  1  bus read strobe.
- s_write_o  out  1  bus write strobe.
- s_addr_o  out  32  bus address.
- s_wdata_o  out  32  bus write data.
- s_rdata_i  in  32  bus read data.
- s_ack_i  in  1  bus acknowledge.
- grant_o  out  NUM_M  one-hot current grant (all zero when idle).
- debug_state  out  1  0 = IDLE, 1 = BUSY.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - grant_o = 0; all m_ack_o, m_err_o, s_read_o, s_write_o = 0; s_addr_o, s_wdata_o, m_rdata_o = 0.
  - State = IDLE; timeout counter = 0; last_grant = NUM_M-1, so master 0 wins the first tie.
- Request definition: master k requests when m_read_i[k] | m_write_i[k]. If both are set, write wins and s_read_o is forced to 0.
- IDLE state:
  - No bus strobes are driven.
  - If lock0_i = 1: the winner is master 0 if it requests; otherwise there is no grant, even if others request.
  - If lock0_i = 0: the winner is the first requesting master scanning last_grant+1, last_grant+2, ..., modulo NUM_M.
  - With a winner, the grant register is loaded and the state moves to BUSY on the next edge. Timeout counter is cleared.
- BUSY state:
  - s_* outputs combinationally follow the granted master's live inputs. Non-granted masters see m_ack_o = 0.
  - When s_ack_i = 1: in the same cycle m_ack_o[g] = 1 and m_rdata_o = s_rdata_i. Next edge: last_grant <= g, grant cleared, state <= IDLE.
  - When the granted master drops both strobes before ack: abort. Next edge goes to IDLE with no ack; last_grant <= g.
  - Timeout: when the counter reaches TIMEOUT-1 without s_ack_i, m_ack_o[g] = 1 and m_err_o[g] = 1 for one cycle, and s_* strobes are deasserted that cycle. Then go to IDLE.
  - If s_ack_i and timeout coincide, the ack wins and m_err_o stays 0.
  - lock0_i rising during BUSY does not preempt; it takes effect at the next arbitration.
- Latency and throughput:
  - Request in IDLE at cycle t gives grant_o and bus strobes at t+1. Ack latency adds zero cycles.
  - At least one IDLE cycle separates consecutive transactions, so a master can drop its strobe after ack. Peak throughput is therefore 1 transaction per 2 cycles plus slave latency.
- s_ack_i arriving in IDLE is ignored. m_rdata_o holds its last value outside ack cycles.
- Reset asserted mid-transaction returns the block to reset values immediately, with no ack or error pulse.
- Counter width is $clog2(TIMEOUT). It never wraps because it is cleared on every grant.

Decomposition:
- bus_pkg holds:
  - arb_state_t enum {IDLE, BUSY}.
  - Bus address constants (SPART base 32'h4000001C, etc.) shared with the bootloader and the decoder.
  - BUS_TIMEOUT_DEFAULT.
- One sub-module, rr_picker: a combinational round-robin picker with inputs req[NUM_M], last[$clog2(NUM_M)], lock0, and outputs valid plus one-hot winner.

Test Plan:
- Single master: m1 write to 32'h4000001C, data 32'h42, slave acks 3 cycles after strobe -> grant_o = 3'b010 at t+1, m_ack_o[1] pulses once, m_err_o = 0, idle cycle follows.
- Round-robin: all three masters read continuously, slave acks immediately -> grant order 0, 1, 2, 0, 1, 2, each separated by one IDLE cycle.
- Lock: lock0_i = 1, m1 and m2 request, m0 idle -> no grant for 20 cycles. m0 then requests -> granted next cycle. Drop lock -> m1 granted after m0 completes.
- Timeout: with TIMEOUT = 16, m2 reads and the slave never acks -> at cycle 16 of BUSY, m_ack_o[2] = m_err_o[2] = 1 for one cycle, then IDLE. Same test with ack on the timeout cycle -> m_err_o = 0.
- Abort and write priority: m1 asserts read and write together -> s_write_o = 1, s_read_o = 0. m1 drops both strobes before ack -> return to IDLE with no m_ack_o.
- Reset mid-BUSY: pull rst_n low during a pending read -> all outputs 0 asynchronously. After release, m0 wins the first tie against m1.
